alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
ID/EX pipeline stage that sits directly upstream of the EX-stage ALU. It registers decoded operands and control each cycle. It translates the 2-bit main-decoder ALU op plus funct fields into the ALU's 4-bit operation code. It resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and detects load-use hazards, inserting a bubble and stalling decode.

Parameters:
XLEN, 32, datapath width; must match ALU operand width
REGA, 5, register address width

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  decode slot holds a real instruction
id_rs1_data  in  XLEN  register-file read port 1
id_rs2_data  in  XLEN  register-file read port 2
id_imm  in  XLEN  sign-extended immediate
id_rs1  in  REGA  source 1 address
id_rs2  in  REGA  source 2 address
id_rd  in  REGA  destination address
id_uses_rs2  in  1  instruction reads rs2 (R-type, store, branch)
id_alu_op  in  2  00 mem-addr, 01 branch, 10 R-type, 11 I-type ALU
id_funct3  in  3  instruction funct3
id_funct7b5  in  1  instruction bit 30
id_alu_src  in  1  1: oprd2 = immediate
id_reg_write, id_mem_read, id_mem_write, id_branch  in  1 each  control bits
flush  in  1  kill the instruction entering EX (branch redirect)
exm_reg_write  in  1  EX/MEM stage writes a register
exm_rd  in  REGA  EX/MEM destination
exm_result  in  XLEN  EX/MEM ALU result
wb_reg_write  in  1  MEM/WB stage writes a register
wb_rd  in  REGA  MEM/WB destination
wb_data  in  XLEN  MEM/WB writeback value
stall_id  out  1  hold PC and IF/ID this cycle
ex_valid  out  1  EX slot valid
oprd1  out  XLEN  ALU operand 1
oprd2  out  XLEN  ALU operand 2
ALU_Operation  out  4  ALU operation code
ex_store_data  out  XLEN  forwarded rs2 for stores
ex_rd  out  REGA  registered destination
ex_reg_write, ex_mem_read, ex_mem_write, ex_branch  out  1 each  registered control
ex_illegal  out  1  unsupported funct combination captured

Behaviour:
- Reset (async, rst_n=0): all registers cleared. ex_valid=0, all ex_* control=0, ex_illegal=0, data/address registers=0, registered ALU_Operation=4'b0010. Consequently oprd1=oprd2=0 and stall_id=0.
- Latency: one cycle. Decode values sampled on clk rise appear at ALU inputs in the next cycle.
- ALU codes: ADD 0010, SUB 0110, AND 0000, OR 0001, SLT 0111. NOR 1100 is reserved and never generated.
- Decode mapping:
  - alu_op 00 -> ADD.
  - alu_op 01 -> SUB.
  - alu_op 10:
    - funct3 000 -> ADD, or SUB if funct7b5=1
    - 111 -> AND
    - 110 -> OR
    - 010 -> SLT
  - alu_op 11: same funct3 mapping as 10, but funct7b5 is ignored (ADDI is always ADD).
  - Any other funct3 -> ADD with ex_illegal=1.
- load_use = id_valid & ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2)).
- stall_id = load_use & ~flush (combinational).
- Next-state update:
  - If flush or load_use: insert a bubble. ex_valid and all ex_* control become 0; data registers keep don't-care values.
  - Otherwise capture decode; ex_valid takes id_valid. If id_valid=0, ex_* control is forced to 0.
- Flush and load_use in the same cycle: flush wins, bubble inserted, stall_id=0.
- Forwarding (combinational on registered rs1/rs2), per source:
  - If exm_reg_write & exm_rd!=0 & exm_rd==src: use exm_result.
  - Else if wb_reg_write & wb_rd!=0 & wb_rd==src: use wb_data.
  - Else use the registered register-file value.
  - EX/MEM has priority over MEM/WB. x0 is never forwarded.
- Operand outputs:
  - oprd1 = fwd_rs1.
  - oprd2 = ex_alu_src ? ex_imm : fwd_rs2.
  - ex_store_data = fwd_rs2 always.
- Outputs are undriven by any other logic; the ALU's result/zero are not consumed here.

Decomposition:
- Shared package alu_pkg: ALU code localparams (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT) and ALUOP_MEM/BR/R/I encodings. The ALU itself is switched to use the same constants.
- One sub-module: alu_ctrl_dec (combinational alu_op/funct3/funct7b5 -> ALU_Operation, illegal), instantiated before the pipeline register.
- Forwarding mux is written inline twice.

Test Plan:
- Reset: rst_n low mid-stream with ex_valid=1 -> immediately ex_valid=0, oprd1=oprd2=0, ALU_Operation=0010, stall_id=0.
- R-type SUB: alu_op=10, funct3=000, funct7b5=1, rs1=5, rs2=3, no forwarding -> next cycle ALU_Operation=0110, oprd1=5, oprd2=3.
- Forward priority: registered rs1=x7; exm_rd=7, exm_result=0xAA; wb_rd=7, wb_data=0xBB; both write -> oprd1=0xAA. With exm_reg_write=0 -> 0xBB. With rd=0 in both stages -> register-file value.
- Load-use: EX holds lw x9 (mem_read=1); decode add x1,x9,x2 -> stall_id=1 for one cycle. Next cycle ex_valid=0, ex_reg_write=0. The following cycle the add issues with forwarding from EX/MEM.
- Flush plus load-use in the same cycle -> stall_id=0, bubble inserted.
- ADDI with funct7b5=1 -> ALU_Operation=0010, oprd2=id_imm (e.g. 0xFFFFFFFC). funct3=001 with alu_op=10 -> ALU_Operation=0010, ex_illegal=1.

Source files
------------

// File: rtl/alu_pkg.sv
// ALU operation codes and main-decoder ALU op encodings, shared by the
// issue stage and the EX-stage ALU.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    ALUOP_MEM = 2'b00,
    ALUOP_BR  = 2'b01,
    ALUOP_R   = 2'b10,
    ALUOP_I   = 2'b11
  } alu_op_e;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Decode-side inputs, forwarding sources and EX-side outputs of the
// ID/EX issue stage, bundled with master (upstream) and slave (stage) views.
interface alu_issue_stage_if #(
  parameter int XLEN = 32,
  parameter int REGA = 5
);
  logic            id_valid;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [REGA-1:0] id_rs1;
  logic [REGA-1:0] id_rs2;
  logic [REGA-1:0] id_rd;
  logic            id_uses_rs2;
  logic [1:0]      id_alu_op;
  logic [2:0]      id_funct3;
  logic            id_funct7b5;
  logic            id_alu_src;
  logic            id_reg_write;
  logic            id_mem_read;
  logic            id_mem_write;
  logic            id_branch;
  logic            flush;
  logic            exm_reg_write;
  logic [REGA-1:0] exm_rd;
  logic [XLEN-1:0] exm_result;
  logic            wb_reg_write;
  logic [REGA-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;

  logic            stall_id;
  logic            ex_valid;
  logic [XLEN-1:0] oprd1;
  logic [XLEN-1:0] oprd2;
  logic [3:0]      ALU_Operation;
  logic [XLEN-1:0] ex_store_data;
  logic [REGA-1:0] ex_rd;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic            ex_branch;
  logic            ex_illegal;

  modport master (
    output id_valid, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_uses_rs2, id_alu_op, id_funct3, id_funct7b5, id_alu_src,
           id_reg_write, id_mem_read, id_mem_write, id_branch, flush,
           exm_reg_write, exm_rd, exm_result, wb_reg_write, wb_rd, wb_data,
    input  stall_id, ex_valid, oprd1, oprd2, ALU_Operation, ex_store_data,
           ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal
  );

  modport slave (
    input  id_valid, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_uses_rs2, id_alu_op, id_funct3, id_funct7b5, id_alu_src,
           id_reg_write, id_mem_read, id_mem_write, id_branch, flush,
           exm_reg_write, exm_rd, exm_result, wb_reg_write, wb_rd, wb_data,
    output stall_id, ex_valid, oprd1, oprd2, ALU_Operation, ex_store_data,
           ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal
  );
endinterface

// File: rtl/alu_ctrl_dec.sv
// ALU control decoder: main-decoder ALU op plus funct fields to the ALU's
// 4-bit operation code, flagging funct3 values the ALU cannot execute.
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] alu_operation,
  output logic       illegal
);

  // I-type shares the R-type funct3 table but never subtracts (ADDI has no SUBI)
  always_comb begin
    alu_operation = ALU_ADD;
    illegal       = 1'b0;
    case (alu_op)
      ALUOP_MEM: alu_operation = ALU_ADD;
      ALUOP_BR:  alu_operation = ALU_SUB;
      default: begin
        case (funct3)
          F3_ADD:  alu_operation = (alu_op == ALUOP_R && funct7b5) ? ALU_SUB : ALU_ADD;
          F3_AND:  alu_operation = ALU_AND;
          F3_OR:   alu_operation = ALU_OR;
          F3_SLT:  alu_operation = ALU_SLT;
          default: begin
            alu_operation = ALU_ADD;
            illegal       = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX pipeline register feeding the ALU: registers decode, forwards from
// EX/MEM and MEM/WB, and stalls decode with a bubble on load-use hazards.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REGA = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_issue_stage_if.slave   bus
);

  logic [3:0]      dec_op;
  logic            dec_illegal;
  logic            load_use;
  logic            bubble;
  logic            take_ctrl;

  logic            ex_valid_q;
  logic [REGA-1:0] ex_rd_q;
  logic [REGA-1:0] ex_rs1_q;
  logic [REGA-1:0] ex_rs2_q;
  logic [XLEN-1:0] ex_rs1_data_q;
  logic [XLEN-1:0] ex_rs2_data_q;
  logic [XLEN-1:0] ex_imm_q;
  logic            ex_alu_src_q;
  logic [3:0]      ex_op_q;
  logic            ex_reg_write_q;
  logic            ex_mem_read_q;
  logic            ex_mem_write_q;
  logic            ex_branch_q;
  logic            ex_illegal_q;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  alu_ctrl_dec u_dec (
    .alu_op        (bus.id_alu_op),
    .funct3        (bus.id_funct3),
    .funct7b5      (bus.id_funct7b5),
    .alu_operation (dec_op),
    .illegal       (dec_illegal)
  );

  assign load_use = bus.id_valid & ex_valid_q & ex_mem_read_q & (ex_rd_q != '0) &
                    ((ex_rd_q == bus.id_rs1) | (bus.id_uses_rs2 & (ex_rd_q == bus.id_rs2)));
  assign bus.stall_id = load_use & ~bus.flush;
  assign bubble       = bus.flush | load_use;
  assign take_ctrl    = ~bubble & bus.id_valid;

  // Data fields are captured even on a bubble; they are meaningless while ex_valid is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q     <= 1'b0;
      ex_rd_q        <= '0;
      ex_rs1_q       <= '0;
      ex_rs2_q       <= '0;
      ex_rs1_data_q  <= '0;
      ex_rs2_data_q  <= '0;
      ex_imm_q       <= '0;
      ex_alu_src_q   <= 1'b0;
      ex_op_q        <= ALU_ADD;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      ex_mem_write_q <= 1'b0;
      ex_branch_q    <= 1'b0;
      ex_illegal_q   <= 1'b0;
    end else begin
      ex_valid_q     <= take_ctrl;
      ex_rd_q        <= bus.id_rd;
      ex_rs1_q       <= bus.id_rs1;
      ex_rs2_q       <= bus.id_rs2;
      ex_rs1_data_q  <= bus.id_rs1_data;
      ex_rs2_data_q  <= bus.id_rs2_data;
      ex_imm_q       <= bus.id_imm;
      ex_alu_src_q   <= bus.id_alu_src;
      ex_op_q        <= dec_op;
      ex_reg_write_q <= take_ctrl & bus.id_reg_write;
      ex_mem_read_q  <= take_ctrl & bus.id_mem_read;
      ex_mem_write_q <= take_ctrl & bus.id_mem_write;
      ex_branch_q    <= take_ctrl & bus.id_branch;
      ex_illegal_q   <= take_ctrl & dec_illegal;
    end
  end

  // The younger EX/MEM result wins over MEM/WB; x0 is hardwired and never forwarded
  always_comb begin
    fwd_rs1 = ex_rs1_data_q;
    if (bus.exm_reg_write && bus.exm_rd != '0 && bus.exm_rd == ex_rs1_q)
      fwd_rs1 = bus.exm_result;
    else if (bus.wb_reg_write && bus.wb_rd != '0 && bus.wb_rd == ex_rs1_q)
      fwd_rs1 = bus.wb_data;
  end

  always_comb begin
    fwd_rs2 = ex_rs2_data_q;
    if (bus.exm_reg_write && bus.exm_rd != '0 && bus.exm_rd == ex_rs2_q)
      fwd_rs2 = bus.exm_result;
    else if (bus.wb_reg_write && bus.wb_rd != '0 && bus.wb_rd == ex_rs2_q)
      fwd_rs2 = bus.wb_data;
  end

  assign bus.oprd1         = fwd_rs1;
  assign bus.oprd2         = ex_alu_src_q ? ex_imm_q : fwd_rs2;
  assign bus.ex_store_data = fwd_rs2;
  assign bus.ALU_Operation = ex_op_q;
  assign bus.ex_valid      = ex_valid_q;
  assign bus.ex_rd         = ex_rd_q;
  assign bus.ex_reg_write  = ex_reg_write_q;
  assign bus.ex_mem_read   = ex_mem_read_q;
  assign bus.ex_mem_write  = ex_mem_write_q;
  assign bus.ex_branch     = ex_branch_q;
  assign bus.ex_illegal    = ex_illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: a reference model predicts the EX
// slot at drive time, and the prediction is popped after the capturing edge.
module tb_alu_issue_stage;

  typedef struct {
    logic        valid, rw, mr, mw, br, illegal;
    logic [3:0]  code;
    logic [31:0] o1, o2, st;
    logic [4:0]  rd;
  } exp_t;

  typedef struct {
    logic        valid, rw, mr, mw, br, illegal, alu_src;
    logic [3:0]  code;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] d1, d2, imm;
  } st_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  st_t  m;

  always #5 clk = ~clk;

  alu_issue_stage_if #(.XLEN(32), .REGA(5)) bus ();

  alu_issue_stage #(.XLEN(32), .REGA(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference decode, written from the opcode table: {illegal, code}
  function automatic logic [4:0] ref_dec(input logic [1:0] op, input logic [2:0] f3, input logic f7);
    logic [4:0] r;
    r = 5'b0_0010;
    if (op == 2'b01) r = 5'b0_0110;
    else if (op[1]) begin
      case (f3)
        3'b000:  r = (op == 2'b10 && f7) ? 5'b0_0110 : 5'b0_0010;
        3'b111:  r = 5'b0_0000;
        3'b110:  r = 5'b0_0001;
        3'b010:  r = 5'b0_0111;
        default: r = 5'b1_0010;
      endcase
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [4:0] src, input logic [31:0] rf);
    if (bus.exm_reg_write && bus.exm_rd != 5'd0 && bus.exm_rd == src) return bus.exm_result;
    if (bus.wb_reg_write && bus.wb_rd != 5'd0 && bus.wb_rd == src) return bus.wb_data;
    return rf;
  endfunction

  task automatic model_reset();
    m = '{default: '0};
    m.code = 4'b0010;
  endtask

  task automatic drive_instr(input logic v, input logic [4:0] rs1, rs2, rd,
                             input logic [31:0] d1, d2, imm, input logic u2,
                             input logic [1:0] op, input logic [2:0] f3, input logic f7,
                             input logic src, rw, mr, mw, br);
    bus.id_valid = v;      bus.id_rs1 = rs1;      bus.id_rs2 = rs2;   bus.id_rd = rd;
    bus.id_rs1_data = d1;  bus.id_rs2_data = d2;  bus.id_imm = imm;   bus.id_uses_rs2 = u2;
    bus.id_alu_op = op;    bus.id_funct3 = f3;    bus.id_funct7b5 = f7;
    bus.id_alu_src = src;  bus.id_reg_write = rw; bus.id_mem_read = mr;
    bus.id_mem_write = mw; bus.id_branch = br;
  endtask

  task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                         input logic ww, input logic [4:0] wrd, input logic [31:0] wdat);
    bus.exm_reg_write = ew; bus.exm_rd = erd; bus.exm_result = eres;
    bus.wb_reg_write = ww;  bus.wb_rd = wrd;  bus.wb_data = wdat;
  endtask

  // Inputs are set beforehand in the low phase; check stall, predict, clock, compare
  task automatic apply_stimulus(input string tag);
    logic  lu;
    logic  take;
    logic [4:0] d;
    exp_t  e;
    lu = bus.id_valid & m.valid & m.mr & (m.rd != 5'd0) &
         ((m.rd == bus.id_rs1) | (bus.id_uses_rs2 & (m.rd == bus.id_rs2)));
    #1 check_output({tag, ":stall"}, 32'(bus.stall_id), 32'(lu & ~bus.flush));
    take = ~(bus.flush | lu) & bus.id_valid;
    d = ref_dec(bus.id_alu_op, bus.id_funct3, bus.id_funct7b5);
    m.valid = take; m.rw = take & bus.id_reg_write; m.mr = take & bus.id_mem_read;
    m.mw = take & bus.id_mem_write; m.br = take & bus.id_branch; m.illegal = take & d[4];
    m.code = d[3:0]; m.rd = bus.id_rd; m.rs1 = bus.id_rs1; m.rs2 = bus.id_rs2;
    m.d1 = bus.id_rs1_data; m.d2 = bus.id_rs2_data; m.imm = bus.id_imm; m.alu_src = bus.id_alu_src;
    e.valid = m.valid; e.rw = m.rw; e.mr = m.mr; e.mw = m.mw; e.br = m.br; e.illegal = m.illegal;
    e.code = m.code; e.rd = m.rd;
    e.o1 = ref_fwd(m.rs1, m.d1);
    e.st = ref_fwd(m.rs2, m.d2);
    e.o2 = m.alu_src ? m.imm : e.st;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_output({tag, ":valid"},   32'(bus.ex_valid),     32'(e.valid));
    check_output({tag, ":ctrl"},    32'({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_branch}),
                                    32'({e.rw, e.mr, e.mw, e.br}));
    check_output({tag, ":illegal"}, 32'(bus.ex_illegal),   32'(e.illegal));
    if (e.valid) begin
      check_output({tag, ":aluop"}, 32'(bus.ALU_Operation), 32'(e.code));
      check_output({tag, ":oprd1"}, bus.oprd1,              e.o1);
      check_output({tag, ":oprd2"}, bus.oprd2,              e.o2);
      check_output({tag, ":store"}, bus.ex_store_data,      e.st);
      check_output({tag, ":rd"},    32'(bus.ex_rd),         32'(e.rd));
    end
  endtask

  task automatic probe_fwd(input string tag, input logic ew, input logic [4:0] erd,
                           input logic [31:0] eres, input logic ww, input logic [4:0] wrd,
                           input logic [31:0] wdat, input logic [31:0] exp1);
    set_fwd(ew, erd, eres, ww, wrd, wdat);
    #1 check_output(tag, bus.oprd1, exp1);
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, ":valid"}, 32'(bus.ex_valid),      32'd0);
    check_output({tag, ":oprd1"}, bus.oprd1,              32'd0);
    check_output({tag, ":oprd2"}, bus.oprd2,              32'd0);
    check_output({tag, ":aluop"}, 32'(bus.ALU_Operation), 32'h2);
    check_output({tag, ":stall"}, 32'(bus.stall_id),      32'd0);
  endtask

  initial begin
    logic [2:0] f3_tab [5];
    f3_tab[0] = 3'b000; f3_tab[1] = 3'b111; f3_tab[2] = 3'b110; f3_tab[3] = 3'b010; f3_tab[4] = 3'b101;

    rst_n = 1'b0;
    bus.flush = 1'b0;
    drive_instr(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // R-type SUB, then asynchronous reset while EX holds it
    @(negedge clk);
    drive_instr(1'b1, 5'd10, 5'd11, 5'd12, 32'd5, 32'd3, 32'd0, 1'b1, 2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus("sub");
    #1 rst_n = 1'b0;
    #1 check_reset_state("midreset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Forwarding priority on registered rs1 = x7
    @(negedge clk);
    drive_instr(1'b1, 5'd7, 5'd8, 5'd3, 32'h11, 32'h22, 32'd0, 1'b1, 2'b10, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus("fwd_base");
    probe_fwd("fwd_exm_over_wb", 1'b1, 5'd7, 32'hAA, 1'b1, 5'd7, 32'hBB, 32'hAA);
    probe_fwd("fwd_wb_only",     1'b0, 5'd7, 32'hAA, 1'b1, 5'd7, 32'hBB, 32'hBB);
    probe_fwd("fwd_x0_none",     1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB, 32'h11);

    // Load-use: lw x9 in EX, dependent add in decode
    @(negedge clk);
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    drive_instr(1'b1, 5'd2, 5'd0, 5'd9, 32'h100, 32'd0, 32'd8, 1'b0, 2'b00, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    apply_stimulus("lw");
    @(negedge clk);
    drive_instr(1'b1, 5'd9, 5'd2, 5'd1, 32'h0, 32'h40, 32'd0, 1'b1, 2'b10, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 check_output("lu_stall_const", 32'(bus.stall_id), 32'd1);
    apply_stimulus("lu_bubble");
    check_output("lu_bubble_valid", 32'(bus.ex_valid), 32'd0);
    @(negedge clk);
    set_fwd(1'b1, 5'd9, 32'h1234, 1'b0, 5'd0, 32'd0);
    apply_stimulus("lu_issue");
    check_output("lu_issue_oprd1", bus.oprd1, 32'h1234);

    // Flush collides with a load-use hazard
    @(negedge clk);
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    drive_instr(1'b1, 5'd2, 5'd0, 5'd9, 32'h100, 32'd0, 32'd8, 1'b0, 2'b00, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    apply_stimulus("lw2");
    @(negedge clk);
    drive_instr(1'b1, 5'd9, 5'd2, 5'd1, 32'h0, 32'h40, 32'd0, 1'b1, 2'b10, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.flush = 1'b1;
    apply_stimulus("flush_lu");
    check_output("flush_lu_valid", 32'(bus.ex_valid), 32'd0);
    bus.flush = 1'b0;

    // ADDI ignores funct7b5; unsupported funct3 is flagged
    @(negedge clk);
    drive_instr(1'b1, 5'd4, 5'd5, 5'd6, 32'h7, 32'h9, 32'hFFFFFFFC, 1'b0, 2'b11, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus("addi");
    check_output("addi_oprd2_const", bus.oprd2, 32'hFFFFFFFC);
    @(negedge clk);
    drive_instr(1'b1, 5'd4, 5'd5, 5'd6, 32'h7, 32'h9, 32'd0, 1'b1, 2'b10, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus("illegal");
    check_output("illegal_const", 32'(bus.ex_illegal), 32'd1);

    // Empty decode slot with control bits asserted must not leak them
    @(negedge clk);
    drive_instr(1'b0, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3, 1'b1, 2'b01, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    apply_stimulus("idle");

    // Randomised R/I/branch/store mix with overlapping forwarding addresses
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      drive_instr(1'b1, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                  $urandom, $urandom, $urandom, 1'($urandom), 2'($urandom),
                  f3_tab[$urandom_range(0, 4)], 1'($urandom), 1'($urandom),
                  1'($urandom), 1'b0, 1'($urandom), 1'($urandom));
      set_fwd(1'($urandom), 5'($urandom_range(0, 3)), $urandom, 1'($urandom), 5'($urandom_range(0, 3)), $urandom);
      bus.flush = ($urandom_range(0, 7) == 0);
      apply_stimulus($sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
